// File: rtl/mmio_arb_pkg.sv
// Shared types for the two-master MMIO arbiter: FSM states, request/response payloads.
package mmio_arb_pkg;

   localparam int unsigned ADDR_W = 64;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              wen;
      logic              ren;
      logic [MASK_W-1:0] mask;
   } mmio_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } mmio_rsp_t;

   // A request is legal only when exactly one of read/write is asked for.
   function automatic logic op_legal(input mmio_req_t r);
      return r.wen ^ r.ren;
   endfunction

endpackage

// File: rtl/mmio_arbiter_rr.sv
// Two-way round-robin grant with a priority pointer register.
//   req_i[1:0]     : request vector
//   update_i       : pointer advances to the loser of the current grant
//   gnt_valid_c_o  : some request is present (combinational)
//   gnt_id_c_o     : winning index (combinational)
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rstn,
   input  logic [1:0] req_i,
   input  logic       update_i,
   output logic       gnt_valid_c_o,
   output logic       gnt_id_c_o
);

   logic ptr_q;
   logic ptr_d;

   // Contention resolved by the pointer; a lone requester wins outright.
   always_comb begin
      gnt_valid_c_o = |req_i;
      gnt_id_c_o    = (req_i == 2'b11) ? ptr_q : req_i[1];
      ptr_d         = ptr_q;
      if (update_i && gnt_valid_c_o) begin
         ptr_d = ~gnt_id_c_o;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/mmio_arbiter.sv
// Shares one MMIO slave port between two masters: round-robin grant, payload
// latch, slave strobes only in ISSUE, timeout for a silent slave, one-cycle ack.
//   clk, rstn (sync, active-low)
//   m0_* / m1_*  : master request ports (req/addr/wdata/wen/ren/mask in,
//                  ack/rdata/err out)
//   s_*          : slave port (address/indata/wen/ren/mask out, outdata/valid in)
module mmio_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   input  logic              m0_wen_i,
   input  logic              m0_ren_i,
   input  logic [MASK_W-1:0] m0_mask_i,
   output logic              m0_ack_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic              m0_err_o,
   input  logic              m1_req_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   input  logic              m1_wen_i,
   input  logic              m1_ren_i,
   input  logic [MASK_W-1:0] m1_mask_i,
   output logic              m1_ack_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_err_o,
   output logic [ADDR_W-1:0] s_address_o,
   output logic [DATA_W-1:0] s_indata_o,
   output logic              s_wen_o,
   output logic              s_ren_o,
   output logic [MASK_W-1:0] s_mask_o,
   input  logic [DATA_W-1:0] s_outdata_i,
   input  logic              s_valid_i
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   mmio_req_t         req_q, req_d;
   logic              id_q, id_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
   logic              s_wen_q, s_wen_d, s_ren_q, s_ren_d;
   logic [MASK_W-1:0] s_mask_q, s_mask_d;
   logic [1:0]        ack_q, ack_d, err_q, err_d;
   logic [DATA_W-1:0] rdata_q [2];
   logic [DATA_W-1:0] rdata_d [2];
   mmio_rsp_t         rsp_c;
   mmio_req_t         m_req_c [2];
   logic              gnt_valid_c, gnt_id_c, upd_c;

   assign m_req_c[0] = '{addr: m0_addr_i, wdata: m0_wdata_i, wen: m0_wen_i,
                         ren: m0_ren_i, mask: m0_mask_i};
   assign m_req_c[1] = '{addr: m1_addr_i, wdata: m1_wdata_i, wen: m1_wen_i,
                         ren: m1_ren_i, mask: m1_mask_i};
   assign upd_c      = (state_q == IDLE);

   rr_arbiter2 u_rr (
      .clk           (clk),
      .rstn          (rstn),
      .req_i         ({m1_req_i, m0_req_i}),
      .update_i      (upd_c),
      .gnt_valid_c_o (gnt_valid_c),
      .gnt_id_c_o    (gnt_id_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: illegal ops skip the slave; ISSUE exits on valid or timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (gnt_valid_c) state_d = op_legal(m_req_c[gnt_id_c]) ? ISSUE : RESP;
         ISSUE: if (s_valid_i || (cnt_q == CNT_LAST)) state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs: payload latch, counter, slave drive and response capture.
   always_comb begin
      req_d     = req_q;
      id_d      = id_q;
      cnt_d     = cnt_q;
      rsp_c     = '{rdata: '0, err: 1'b1};
      s_addr_d  = '0;
      s_wdata_d = '0;
      s_wen_d   = 1'b0;
      s_ren_d   = 1'b0;
      s_mask_d  = '0;
      ack_d     = '0;
      err_d     = '0;
      rdata_d   = '{default: '0};
      unique case (state_q)
         IDLE: begin
            if (gnt_valid_c) begin
               req_d = m_req_c[gnt_id_c];
               id_d  = gnt_id_c;
               cnt_d = '0;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (s_valid_i) begin
               rsp_c.err   = 1'b0;
               rsp_c.rdata = req_q.ren ? s_outdata_i : '0;
            end
         end
         default: ;
      endcase
      // Strobes are high for exactly the cycles spent in ISSUE.
      if (state_d == ISSUE) begin
         s_addr_d  = req_d.addr;
         s_wdata_d = req_d.wdata;
         s_wen_d   = req_d.wen;
         s_ren_d   = req_d.ren;
         s_mask_d  = req_d.mask;
      end
      if ((state_d == RESP) && (state_q != RESP)) begin
         ack_d[id_d]   = 1'b1;
         err_d[id_d]   = rsp_c.err;
         rdata_d[id_d] = rsp_c.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         req_q     <= '0;
         id_q      <= 1'b0;
         cnt_q     <= '0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_wen_q   <= 1'b0;
         s_ren_q   <= 1'b0;
         s_mask_q  <= '0;
         ack_q     <= '0;
         err_q     <= '0;
         rdata_q   <= '{default: '0};
      end else begin
         req_q     <= req_d;
         id_q      <= id_d;
         cnt_q     <= cnt_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_wen_q   <= s_wen_d;
         s_ren_q   <= s_ren_d;
         s_mask_q  <= s_mask_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign m0_ack_o    = ack_q[0];
   assign m1_ack_o    = ack_q[1];
   assign m0_err_o    = err_q[0];
   assign m1_err_o    = err_q[1];
   assign m0_rdata_o  = rdata_q[0];
   assign m1_rdata_o  = rdata_q[1];
   assign s_address_o = s_addr_q;
   assign s_indata_o  = s_wdata_q;
   assign s_wen_o     = s_wen_q;
   assign s_ren_o     = s_ren_q;
   assign s_mask_o    = s_mask_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter: directed cases plus randomized
// transactions predicted by a transaction-level latency/response model.
module tb_mmio_arbiter;

   localparam int unsigned TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        m_req   [2];
   logic [63:0] m_addr  [2];
   logic [63:0] m_wdata [2];
   logic        m_wen   [2];
   logic        m_ren   [2];
   logic [7:0]  m_mask  [2];
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic [63:0] m0_rdata, m1_rdata;
   logic [63:0] s_address, s_indata;
   logic        s_wen, s_ren;
   logic [7:0]  s_mask;
   logic [63:0] s_outdata = '0;
   logic        s_valid = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Slave model state and bus observations.
   int          slave_wait = 0;
   logic [63:0] key = '0;
   int          issue_idx = 0;
   int          wen_cyc = 0;
   int          ren_cyc = 0;
   int          stray = 0;
   logic [63:0] last_addr = '0, last_wdata = '0;
   logic [7:0]  last_mask = '0;

   int ptr = 0;

   mmio_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req_i(m_req[0]), .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]),
      .m0_wen_i(m_wen[0]), .m0_ren_i(m_ren[0]), .m0_mask_i(m_mask[0]),
      .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
      .m1_req_i(m_req[1]), .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]),
      .m1_wen_i(m_wen[1]), .m1_ren_i(m_ren[1]), .m1_mask_i(m_mask[1]),
      .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
      .s_address_o(s_address), .s_indata_o(s_indata), .s_wen_o(s_wen),
      .s_ren_o(s_ren), .s_mask_o(s_mask), .s_outdata_i(s_outdata),
      .s_valid_i(s_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: valid after slave_wait strobed cycles; returns address ^ key.
   always @(negedge clk) begin
      if (s_wen || s_ren) begin
         if (s_wen) wen_cyc++;
         if (s_ren) ren_cyc++;
         if (s_wen && s_ren) stray++;
         last_addr  = s_address;
         last_wdata = s_indata;
         last_mask  = s_mask;
         s_valid    = (issue_idx >= slave_wait);
         s_outdata  = s_address ^ key;
         issue_idx++;
      end else begin
         if ((s_address != 0) || (s_indata != 0) || (s_mask != 0)) stray++;
         issue_idx = 0;
         s_valid   = 1'b0;
         s_outdata = '0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Reference model, per transaction, from the protocol timing rules.
   function automatic int exp_lat(input logic wen, input logic ren, input int w);
      if (wen == ren) return 1;
      if (w >= int'(TIMEOUT)) return int'(TIMEOUT) + 1;
      return w + 2;
   endfunction

   function automatic logic exp_err(input logic wen, input logic ren, input int w);
      return (wen == ren) || (w >= int'(TIMEOUT));
   endfunction

   function automatic int exp_strobes(input logic wen, input logic ren, input int w);
      if (wen == ren) return 0;
      return (w >= int'(TIMEOUT)) ? int'(TIMEOUT) : w + 1;
   endfunction

   task automatic set_master(input int m, input logic [63:0] a, input logic [63:0] d,
                             input logic we, input logic re, input logic [7:0] mk);
      m_addr[m] = a; m_wdata[m] = d; m_wen[m] = we; m_ren[m] = re; m_mask[m] = mk;
   endtask

   task automatic run_txn(input string tag, input logic [1:0] act);
      int          exp_l [2];
      logic        exp_e [2];
      logic [63:0] exp_r [2];
      int          got_l [2];
      logic        got_e [2];
      logic [63:0] got_r [2];
      int          first, second, t0, w0, r0, st0, ew, er, spurious;
      logic [1:0]  pending, ack_now;
      @(negedge clk); #1;
      for (int m = 0; m < 2; m++) begin
         if (act[m]) m_req[m] = 1'b1;
         got_l[m] = -1; got_e[m] = 1'bx; got_r[m] = 'x;
         exp_e[m] = exp_err(m_wen[m], m_ren[m], slave_wait);
         exp_r[m] = (!exp_e[m] && m_ren[m]) ? (m_addr[m] ^ key) : 64'h0;
      end
      t0 = cyc; w0 = wen_cyc; r0 = ren_cyc; st0 = stray;
      first = (act == 2'b11) ? ptr : (act[1] ? 1 : 0);
      second = 1 - first;
      exp_l[first] = exp_lat(m_wen[first], m_ren[first], slave_wait);
      exp_l[second] = exp_l[first] + 1 + exp_lat(m_wen[second], m_ren[second], slave_wait);
      ptr = (act == 2'b11) ? first : second;
      ew = 0; er = 0;
      for (int m = 0; m < 2; m++) begin
         if (act[m] && m_wen[m]) ew += exp_strobes(m_wen[m], m_ren[m], slave_wait);
         if (act[m] && m_ren[m]) er += exp_strobes(m_wen[m], m_ren[m], slave_wait);
      end
      pending = act; spurious = 0;
      for (int k = 0; k < 80 && pending != 2'b00; k++) begin
         @(negedge clk); #1;
         ack_now = {m1_ack, m0_ack};
         for (int m = 0; m < 2; m++) begin
            if (ack_now[m]) begin
               if (pending[m]) begin
                  got_l[m] = cyc - t0;
                  got_e[m] = (m == 0) ? m0_err : m1_err;
                  got_r[m] = (m == 0) ? m0_rdata : m1_rdata;
                  pending[m] = 1'b0;
                  m_req[m] = 1'b0;
               end else begin
                  spurious++;
               end
            end
         end
      end
      check({tag, " all_acked"}, 64'(pending), 64'h0);
      check({tag, " spurious_ack"}, 64'(spurious), 64'h0);
      for (int m = 0; m < 2; m++) begin
         if (act[m]) begin
            check($sformatf("%s m%0d ack_cycle", tag, m), 64'(got_l[m]), 64'(exp_l[m]));
            check($sformatf("%s m%0d err", tag, m), 64'(got_e[m]), 64'(exp_e[m]));
            check($sformatf("%s m%0d rdata", tag, m), got_r[m], exp_r[m]);
         end
      end
      check({tag, " wen_cycles"}, 64'(wen_cyc - w0), 64'(ew));
      check({tag, " ren_cycles"}, 64'(ren_cyc - r0), 64'(er));
      check({tag, " stray_bus"}, 64'(stray - st0), 64'h0);
      if (act != 2'b11 && exp_strobes(m_wen[first], m_ren[first], slave_wait) > 0) begin
         check({tag, " s_addr"}, last_addr, m_addr[first]);
         check({tag, " s_wdata"}, last_wdata, m_wdata[first]);
         check({tag, " s_mask"}, 64'(last_mask), 64'(m_mask[first]));
      end
   endtask

   initial begin
      int spur;
      logic [1:0] act;
      logic [1:0] op;
      for (int m = 0; m < 2; m++) begin
         m_req[m] = 1'b0;
         set_master(m, '0, '0, 1'b0, 1'b0, '0);
      end

      // Reset state.
      repeat (3) @(negedge clk);
      #1;
      check("reset acks_errs_strobes", 64'({m0_ack, m1_ack, m0_err, m1_err, s_wen, s_ren}), 64'h0);
      check("reset rdata", m0_rdata | m1_rdata, 64'h0);
      check("reset s_bus", s_address | s_indata | 64'(s_mask), 64'h0);
      rstn = 1'b1;

      // Simultaneous writes from reset: m0 first, then m1.
      slave_wait = 0; key = 64'h0;
      set_master(0, 64'h1000, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 8'hFF);
      set_master(1, 64'h2000, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 8'hF0);
      run_txn("both_writes", 2'b11);

      // m0 read of mtime returning 0x1234.
      key = 64'h0200_BFF8 ^ 64'h1234;
      set_master(0, 64'h0200_BFF8, 64'h0, 1'b0, 1'b1, 8'hFF);
      run_txn("m0_read_mtime", 2'b01);

      // m1 masked write.
      set_master(1, 64'h0200_4000, 64'hAABBCCDD_11223344, 1'b1, 1'b0, 8'h0F);
      run_txn("m1_mask_write", 2'b10);

      // Wait states.
      slave_wait = 3; key = 64'h5555_0000_AAAA_0000;
      set_master(0, 64'h40, 64'h0, 1'b0, 1'b1, 8'hFF);
      run_txn("m0_read_wait3", 2'b01);

      // Silent slave: timeout.
      slave_wait = 1000;
      set_master(0, 64'h0200_4008, 64'h0, 1'b0, 1'b1, 8'hFF);
      run_txn("m0_timeout", 2'b01);

      // Illegal op: no strobe, immediate error.
      slave_wait = 0;
      set_master(0, 64'h80, 64'h77, 1'b1, 1'b1, 8'hFF);
      run_txn("m0_illegal", 2'b01);

      // Reset during ISSUE aborts without ack.
      slave_wait = 1000;
      set_master(0, 64'h88, 64'h0, 1'b0, 1'b1, 8'hFF);
      @(negedge clk); #1;
      m_req[0] = 1'b1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      check("rst_mid s_ren_in_issue", 64'(s_ren), 64'h1);
      rstn = 1'b0; m_req[0] = 1'b0;
      @(negedge clk); #1;
      check("rst_mid outputs", 64'({m0_ack, m1_ack, m0_err, m1_err, s_wen, s_ren}), 64'h0);
      check("rst_mid s_bus", s_address | s_indata | 64'(s_mask) | m0_rdata | m1_rdata, 64'h0);
      rstn = 1'b1; spur = 0;
      repeat (5) begin
         @(negedge clk); #1;
         if (m0_ack || m1_ack) spur++;
      end
      check("rst_mid no_ack", 64'(spur), 64'h0);
      ptr = 0;
      slave_wait = 0; key = 64'h0F0F;
      set_master(0, 64'h100, 64'h0, 1'b0, 1'b1, 8'hFF);
      set_master(1, 64'h200, 64'h0, 1'b0, 1'b1, 8'hFF);
      run_txn("after_rst_both", 2'b11);

      // Randomized transactions.
      for (int i = 0; i < 40; i++) begin
         act = 2'($urandom_range(1, 3));
         slave_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20))
                                                   : int'($urandom_range(0, 2));
         key = {$urandom, $urandom};
         for (int m = 0; m < 2; m++) begin
            op = 2'($urandom_range(0, 7) == 0 ? $urandom_range(0, 3) : $urandom_range(1, 2));
            set_master(m, {$urandom, $urandom}, {$urandom, $urandom}, op[1], op[0],
                       8'($urandom));
         end
         run_txn($sformatf("rand%0d", i), act);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter that shares a single MMIO slave port (mtime/mtimecmp timer and any device on the same bus) between requesters, typically the core data port (master 0) and a kernel-side debug/DMA port (master 1). It picks one request per transaction with round-robin priority, drives the slave strobes for exactly the transaction's lifetime, captures the slave response, and returns it with a one-cycle acknowledge. A timeout counter guarantees forward progress when the slave never asserts valid.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width; mask width is DATA_W/8
- TIMEOUT, 16, max cycles in ISSUE before error completion (≥2)

- clk  in  1  clock
- rstn  in  1  reset rstn, synchronous, active-low; clock clk
- m0_req_i / m1_req_i  in  1  request; held with payload stable until matching ack
- m0_addr_i / m1_addr_i  in  ADDR_W  target address
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data
- m0_wen_i / m1_wen_i  in  1  write request
- m0_ren_i / m1_ren_i  in  1  read request
- m0_mask_i / m1_mask_i  in  DATA_W/8  byte-write mask
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data, valid while ack high
- m0_err_o / m1_err_o  out  1  error flag, valid while ack high
- s_address_o  out  ADDR_W  slave address
- s_indata_o  out  DATA_W  slave write data
- s_wen_o, s_ren_o  out  1  slave strobes
- s_mask_o  out  DATA_W/8  slave byte mask
- s_outdata_i  in  DATA_W  slave read data
- s_valid_i  in  1  slave response valid (may be constant 1)

## Operation
- FSM: IDLE → ISSUE → RESP → IDLE.
- IDLE: if any mN_req_i, grant winner, latch its addr/wdata/wen/ren/mask and grant id; go ISSUE. Otherwise stay.
- Arbitration: single request wins directly; both requesting → master pointed to by priority pointer wins. Pointer moves to the non-winner after every grant.
- Illegal op (wen=ren=1, or wen=ren=0 with req=1): granted, no slave access, go straight to RESP with err=1, rdata=0.
- ISSUE: slave outputs driven from latched payload. On s_valid_i=1: capture s_outdata_i (reads; 0 for writes), err=0, go RESP. On timeout counter reaching TIMEOUT-1 without valid: err=1, rdata=0, go RESP.
- RESP: ack high one cycle for granted master only, rdata/err from capture; go IDLE.
- Requester dropping req mid-transaction: transaction still completes; ack pulse still issued.
- Outside ISSUE, all s_* outputs are 0 (no stray writes/reads).
- Slave strobes asserted only while in ISSUE, so a zero-wait slave sees exactly one write edge per transaction.

## Timing
- Reset: state=IDLE, pointer=master 0, counter=0; all mN_ack_o, mN_err_o, mN_rdata_o, s_* outputs = 0. Reset mid-transaction aborts it without ack.
- Zero-wait slave: req sampled in IDLE cycle N; ISSUE cycle N+1 (strobes high); ack cycle N+2. Back-to-back throughput: one transaction per 3 cycles.
- Wait states: ack at N+2+W for W cycles of s_valid_i low.
- Timeout: ack with err=1 exactly TIMEOUT+1 cycles after the IDLE grant cycle.
- Counter width clog2(TIMEOUT); clears on entry to ISSUE, no wrap possible.
- Master stalled by the other: same master re-arbitrated in the IDLE cycle following RESP; round-robin guarantees service within one foreign transaction.

## Structure
- Package mmio_arb_pkg: state enum (IDLE, ISSUE, RESP), struct MmioReq {addr, wdata, wen, ren, mask}, struct MmioRsp {rdata, err}.
- Sub-module rr_arbiter2: 2-way round-robin grant with pointer register and update strobe; reused for future bus arbitration.
- Top module holds FSM, payload latch, timeout counter, response capture.

## Test plan
- m0 read of mtime address, slave valid=1, s_outdata_i=0x1234 → m0_ack_o at cycle N+2, m0_rdata_o=0x1234, err=0; s_ren_o high exactly one cycle.
- Both masters request writes simultaneously from reset → m0 served first (acks at N+2), m1 next (ack at N+5); pointer then favours m0 again.
- m1 write mask 0x0F data 0xAABBCCDD_11223344 → s_mask_o=0x0F, s_indata_o matches, s_wen_o high exactly one cycle.
- Slave valid held 0, TIMEOUT=16 → ack with err=1, rdata=0 at grant+17; s_* return to 0.
- m0 request with wen=ren=1 → no slave strobe, ack at N+1 with err=1.
- rstn low during ISSUE → no ack, all outputs 0 next cycle, pointer back to m0.
